// File: rtl/mem_host_pkg.sv
// Shared types and sizing for the cache-line to host-bus beat transfer block.
package mem_host_pkg;

   localparam int unsigned LINE_W = 512;
   localparam int unsigned BEAT_W = 64;
   localparam int unsigned BEATS  = LINE_W / BEAT_W;
   localparam int unsigned ADDR_W = 32;
   localparam int unsigned CNT_W  = $clog2(BEATS);
   localparam int unsigned LINE_B = LINE_W / 8;

   typedef enum logic [1:0] {
      OP_NONE = 2'b00,
      OP_RD   = 2'b01,
      OP_WR   = 2'b10
   } op_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_REQ,
      ST_RD_DATA,
      ST_WR_REQ,
      ST_WR_DATA,
      ST_WR_ACK,
      ST_DONE
   } xfer_state_t;

   // Latched request payload presented on the host request channel.
   typedef struct packed {
      logic              wr;
      logic [ADDR_W-1:0] addr;
   } host_req_t;

   function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] a);
      return a & ~ADDR_W'(LINE_B - 1);
   endfunction

endpackage

// File: rtl/host_line_xfer_if.sv
// Host memory bus: request, write-beat, read-beat and write-ack channels.
interface host_line_xfer_if;
   import mem_host_pkg::*;

   logic              req_valid;
   logic              req_ready;
   logic              req_wr;
   logic [ADDR_W-1:0] req_addr;
   logic [BEAT_W-1:0] wdata;
   logic              wdata_valid;
   logic              wdata_ready;
   logic [BEAT_W-1:0] rdata;
   logic              rdata_valid;
   logic              wr_ack;

   modport master (
      output req_valid, req_wr, req_addr, wdata, wdata_valid,
      input  req_ready, wdata_ready, rdata, rdata_valid, wr_ack
   );

   modport slave (
      input  req_valid, req_wr, req_addr, wdata, wdata_valid,
      output req_ready, wdata_ready, rdata, rdata_valid, wr_ack
   );

endinterface

// File: rtl/host_line_xfer.sv
// Splits 512-bit cache line reads/writes into eight 64-bit host bus beats,
// one transfer in flight, with registered outputs throughout.
module host_line_xfer
   import mem_host_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic [1:0]         op_host,
   input  logic [ADDR_W-1:0]  AddrOut_host,
   input  logic [LINE_W-1:0]  DataOut_host,
   output logic [LINE_W-1:0]  DataIn_host,
   output logic               rd_valid_host,
   output logic               tx_done_host,
   output logic               busy,
   host_line_xfer_if.master   host
);

   xfer_state_t       state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   host_req_t         req_q, req_d;
   logic [LINE_W-1:0] wline_q, wline_d;
   logic [LINE_W-1:0] rline_q, rline_d;

   logic              req_valid_q, req_valid_d;
   logic              req_wr_q, req_wr_d;
   logic [ADDR_W-1:0] req_addr_q, req_addr_d;
   logic [BEAT_W-1:0] wdata_q, wdata_d;
   logic              wdata_valid_q, wdata_valid_d;
   logic              tx_done_q, tx_done_d;
   logic              rd_valid_q, rd_valid_d;
   logic              busy_q, busy_d;

   logic last_beat;
   assign last_beat = (cnt_q == CNT_W'(BEATS - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (op_host == OP_RD)      state_d = ST_RD_REQ;
            else if (op_host == OP_WR) state_d = ST_WR_REQ;
         end
         ST_RD_REQ:  if (req_valid_q && host.req_ready) state_d = ST_RD_DATA;
         ST_RD_DATA: if (host.rdata_valid && last_beat) state_d = ST_DONE;
         ST_WR_REQ:  if (req_valid_q && host.req_ready) state_d = ST_WR_DATA;
         ST_WR_DATA: if (wdata_valid_q && host.wdata_ready && last_beat) state_d = ST_WR_ACK;
         ST_WR_ACK:  if (host.wr_ack) state_d = ST_DONE;
         ST_DONE:    state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   // Beat counter, request latch and line registers.
   always_comb begin
      cnt_d   = cnt_q;
      req_d   = req_q;
      wline_d = wline_q;
      rline_d = rline_q;
      unique case (state_q)
         ST_IDLE: begin
            if (op_host == OP_RD) begin
               req_d.wr   = 1'b0;
               req_d.addr = line_align(AddrOut_host);
            end else if (op_host == OP_WR) begin
               req_d.wr   = 1'b1;
               req_d.addr = line_align(AddrOut_host);
               wline_d    = DataOut_host;
            end
         end
         ST_RD_REQ, ST_WR_REQ: begin
            if (req_valid_q && host.req_ready) cnt_d = '0;
         end
         ST_RD_DATA: begin
            if (host.rdata_valid) begin
               rline_d[BEAT_W*cnt_q +: BEAT_W] = host.rdata;
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_WR_DATA: begin
            if (wdata_valid_q && host.wdata_ready) cnt_d = cnt_q + CNT_W'(1);
         end
         default: ;
      endcase
   end

   // Outputs are decoded from the next state so they line up with it when registered.
   always_comb begin
      busy_d        = (state_d != ST_IDLE);
      req_valid_d   = (state_d == ST_RD_REQ) || (state_d == ST_WR_REQ);
      req_wr_d      = (state_d == ST_WR_REQ);
      req_addr_d    = req_valid_d ? req_d.addr : '0;
      wdata_valid_d = (state_d == ST_WR_DATA);
      wdata_d       = wdata_valid_d ? wline_d[BEAT_W*cnt_d +: BEAT_W] : '0;
      tx_done_d     = (state_d == ST_DONE);
      rd_valid_d    = tx_done_d && !req_d.wr;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         req_q   <= '0;
         wline_q <= '0;
         rline_q <= '0;
      end else begin
         cnt_q   <= cnt_d;
         req_q   <= req_d;
         wline_q <= wline_d;
         rline_q <= rline_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         req_valid_q   <= 1'b0;
         req_wr_q      <= 1'b0;
         req_addr_q    <= '0;
         wdata_q       <= '0;
         wdata_valid_q <= 1'b0;
         tx_done_q     <= 1'b0;
         rd_valid_q    <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         req_valid_q   <= req_valid_d;
         req_wr_q      <= req_wr_d;
         req_addr_q    <= req_addr_d;
         wdata_q       <= wdata_d;
         wdata_valid_q <= wdata_valid_d;
         tx_done_q     <= tx_done_d;
         rd_valid_q    <= rd_valid_d;
         busy_q        <= busy_d;
      end
   end

   assign host.req_valid   = req_valid_q;
   assign host.req_wr      = req_wr_q;
   assign host.req_addr    = req_addr_q;
   assign host.wdata       = wdata_q;
   assign host.wdata_valid = wdata_valid_q;
   assign DataIn_host      = rline_q;
   assign rd_valid_host    = rd_valid_q;
   assign tx_done_host     = tx_done_q;
   assign busy             = busy_q;

endmodule

// File: doc/host_line_xfer.md
# host_line_xfer

Downstream neighbour of the CPU memory system: converts the cache controller's 512-bit line requests (op_host, AddrOut_host, DataOut_host) into 64-bit beat transfers on the host memory bus. It returns filled lines on DataIn_host with rd_valid_host/tx_done_host pulses. One transfer is in flight at a time. A beat counter and a small FSM sequence the request, data and acknowledge phases.

## Interface
- LINE_W, 512, cache line width in bits
- BEAT_W, 64, host bus beat width; BEATS = LINE_W/BEAT_W = 8
- ADDR_W, 32, address width
- clk  in  1  clock; single clock domain
- rst_n  in  1  reset; synchronous, active-low
- op_host  in  2  operation: 00 none, 01 line read, 10 line write, 11 treated as none
- AddrOut_host  in  ADDR_W  line address from the cache controller; low 6 bits ignored
- DataOut_host  in  LINE_W  line to write back
- DataIn_host  out  LINE_W  assembled read line
- rd_valid_host  out  1  one-cycle pulse: DataIn_host holds a new line
- tx_done_host  out  1  one-cycle pulse: transfer complete
- busy  out  1  high whenever the FSM state is not IDLE
- req_valid / req_ready  out / in  1 / 1  host request handshake
- req_wr  out  1  request type: 1 write, 0 read
- req_addr  out  ADDR_W  line-aligned address; bits [5:0] are 0
- wdata / wdata_valid / wdata_ready  out / out / in  BEAT_W / 1 / 1  write beat channel
- rdata / rdata_valid  in / in  BEAT_W / 1  read beat channel; no backpressure
- wr_ack  in  1  host write-complete pulse

## Operation
- States: IDLE, RD_REQ, RD_DATA, WR_REQ, WR_DATA, WR_ACK, DONE.
- IDLE:
  - Samples op_host every cycle.
  - On 01, latch the aligned address; go to RD_REQ.
  - On 10, latch the aligned address and DataOut_host; go to WR_REQ.
  - On 00 or 11, stay in IDLE.
- RD_REQ / WR_REQ:
  - Hold req_valid=1 with stable req_addr and req_wr.
  - Advance when req_valid && req_ready; clear the beat counter at the same time.
- RD_DATA:
  - Each rdata_valid stores rdata into DataIn_host[BEAT_W*cnt +: BEAT_W], then increments cnt.
  - Beat 0 maps to bits [63:0].
  - The beat taken while cnt==7 moves the FSM to DONE.
- WR_DATA:
  - wdata = latched line slice cnt; wdata_valid=1.
  - Each wdata_ready increments cnt.
  - The accept while cnt==7 moves the FSM to WR_ACK.
- WR_ACK:
  - Wait for wr_ack, then go to DONE.
  - wr_ack is sampled only in this state.
- DONE:
  - tx_done_host=1 for exactly one cycle.
  - rd_valid_host=1 in the same cycle, for reads only.
  - Unconditional return to IDLE.
- op_host is not sampled in any state except IDLE. The cache controller must drop op_host in the cycle after tx_done_host.
- DataIn_host holds its last assembled value until the next read overwrites it. Beats of a read in progress are visible as they arrive; consumers use DataIn_host only on rd_valid_host.
- rdata_valid outside RD_DATA is ignored.

## Timing
- Reset values:
  - FSM state IDLE, cnt=0, DataIn_host=0.
  - All valid, done, busy and req_* outputs 0; wdata=0.
- Reset asserted mid-transfer: on the next edge the FSM is in IDLE with all outputs at reset values. Host beats already in flight are then ignored.
- Read, with req_ready and rdata_valid continuously high:
  - op_host seen at cycle t0; req_valid at t1.
  - Beats accepted t2..t9.
  - tx_done_host and rd_valid_host at t10; busy low at t11.
- Write, with ready signals high and wr_ack at the first WR_ACK cycle:
  - req at t1; beats t2..t9.
  - WR_ACK at t10; DONE at t11.
- Stall behaviour: a low req_ready or wdata_ready holds the outputs stable; gaps in rdata_valid simply stall cnt.
- Back-to-back transfers: a new op is accepted at the earliest in the cycle after DONE.

## Structure
- Shared package mem_host_pkg contains:
  - op_t enum: OP_NONE=2'b00, OP_RD=2'b01, OP_WR=2'b10.
  - xfer_state_t enum.
  - Constants LINE_W, BEAT_W, BEATS.
- No sub-module is required. Counter, line register and FSM all live in host_line_xfer.

## Test plan
- Read, host always ready: op=01, addr=0x0001_2345 with rdata beat i = 0x1111_1111_1111_1111*i. Expect req_addr=0x0001_2340, req_wr=0, DataIn_host slices equal to those beats, and tx_done_host plus rd_valid_host pulsed at t10.
- Write with wdata_ready toggling 1/0: op=10, DataOut_host beat i = 0xA0+i. Expect wdata to hold during stalls, beats emitted in order 0xA0..0xA7, then wait for wr_ack. tx_done_host pulses once; rd_valid_host stays 0.
- req_ready held low for 5 cycles: req_valid and req_addr stay stable; transfer completes normally afterwards.
- Spurious inputs: rdata_valid in IDLE and wr_ack during WR_DATA are ignored. tx_done_host must not pulse before the real wr_ack arrives in WR_ACK.
- rst_n low during the 4th read beat: next edge gives FSM IDLE, busy=0, DataIn_host=0. A following read completes with correct data.
- Back-to-back: read immediately followed by write with op dropped for one cycle. Exactly one tx_done_host per op, and no duplicate request.
